// File: rtl/rtf65002_dcache_fill.sv
// Data-cache line fill: 4-beat wrapping Wishbone read burst, then an in-order 4-cycle cache
// write whose word-3 write commits the tag. RTF65002_DCACHE_FILL_TIMEOUT_EN adds an ack timeout.
module rtf65002_dcache_fill #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        miss_i,
  input  logic [31:0] miss_adr_i,
  output logic        busy_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [2:0]  cti_o,
  output logic [1:0]  bte_o,
  output logic [31:0] adr_o,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic [31:0] dat_i,
  output logic        crit_vld_o,
  output logic [31:0] crit_dat_o,
  output logic        wr_o,
  output logic [31:0] wadr_o,
  output logic [31:0] wdat_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {StIdle, StBurst, StWrite} state_e;

  state_e      state_q;
  logic [1:0]  beats_q;
  logic [31:0] line_buf [4];
  logic        abort;
  logic [1:0]  next_k;

  assign next_k = wadr_o[1:0] + 2'd1;

`ifdef RTF65002_DCACHE_FILL_TIMEOUT_EN
  logic [7:0] tmo_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else if (state_q != StBurst || ack_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 8'd1;
    end
  end

  assign abort = err_i || (!ack_i && (tmo_q == 8'(TIMEOUT - 1)));
`else
  assign abort = err_i;
`endif

  // Line buffer is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (state_q == StBurst && ack_i && !abort) begin
      line_buf[adr_o[1:0]] <= dat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      beats_q    <= '0;
      busy_o     <= 1'b0;
      cyc_o      <= 1'b0;
      stb_o      <= 1'b0;
      cti_o      <= 3'b000;
      bte_o      <= 2'b00;
      adr_o      <= '0;
      crit_vld_o <= 1'b0;
      crit_dat_o <= '0;
      wr_o       <= 1'b0;
      wadr_o     <= '0;
      wdat_o     <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      crit_vld_o <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      wr_o       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (miss_i) begin
            state_q <= StBurst;
            beats_q <= '0;
            busy_o  <= 1'b1;
            cyc_o   <= 1'b1;
            stb_o   <= 1'b1;
            cti_o   <= 3'b010;
            bte_o   <= 2'b01;
            adr_o   <= miss_adr_i;
          end
        end
        StBurst: begin
          if (abort) begin
            state_q <= StIdle;
            busy_o  <= 1'b0;
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            cti_o   <= 3'b000;
            bte_o   <= 2'b00;
            err_o   <= 1'b1;
          end else if (ack_i) begin
            beats_q     <= beats_q + 2'd1;
            adr_o[1:0]  <= adr_o[1:0] + 2'd1;
            if (beats_q == 2'd0) begin
              crit_vld_o <= 1'b1;
              crit_dat_o <= dat_i;
            end
            if (beats_q == 2'd2) begin
              cti_o <= 3'b111;
            end
            if (beats_q == 2'd3) begin
              state_q <= StWrite;
              cyc_o   <= 1'b0;
              stb_o   <= 1'b0;
              cti_o   <= 3'b000;
              bte_o   <= 2'b00;
              wr_o    <= 1'b1;
              wadr_o  <= {adr_o[31:2], 2'b00};
              // Word 0 may be the beat landing in the buffer this very cycle.
              wdat_o  <= (adr_o[1:0] == 2'd0) ? dat_i : line_buf[0];
            end
          end
        end
        StWrite: begin
          if (wadr_o[1:0] == 2'd3) begin
            state_q <= StIdle;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end else begin
            wr_o        <= 1'b1;
            wadr_o[1:0] <= next_k;
            wdat_o      <= line_buf[next_k];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
